// File: rtl/cache_tag_lookup.sv
// rtl/cache_tag_lookup.sv - set-associative tag array with registered lookup, fill and flush
module cache_tag_lookup #(
  parameter int TAG_W = 8,
  parameter int SETS  = 32,
  parameter int WAYS  = 4,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  input  logic             fill_valid,
  output logic             fill_ready,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [TAG_W-1:0] fill_tag,
  output logic [WAY_W-1:0] fill_way,
  output logic             fill_done,
  input  logic             flush_req,
  output logic             flush_busy
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q;
  logic [WAYS-1:0]    valid_q [SETS];
  logic [TAG_W-1:0]   tag_mem [SETS][WAYS];
  logic [WAY_W-1:0]   rr_q    [SETS];

  logic               lk_acc, fill_acc;
  logic               lk_hit;
  logic [WAY_W-1:0]   lk_way;
  logic               f_match, f_inv, rr_adv;
  logic [WAY_W-1:0]   f_mway, f_iway, f_sel;

  assign lk_ready   = (state_q == IDLE) && !flush_req;
  assign fill_ready = lk_ready;
  assign lk_acc     = lk_valid && lk_ready;
  assign fill_acc   = fill_valid && fill_ready;
  assign flush_busy = (state_q == FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == FLUSH) ? cnt_q + IDX_W'(1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req) state_d = FLUSH;
      FLUSH:   if (cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Descending scans so the lowest-numbered qualifying way wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_way  = '0;
    f_match = 1'b0;
    f_mway  = '0;
    f_inv   = 1'b0;
    f_iway  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_index][w] && tag_mem[lk_index][w] == lk_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (valid_q[fill_index][w] && tag_mem[fill_index][w] == fill_tag) begin
        f_match = 1'b1;
        f_mway  = WAY_W'(w);
      end
      if (!valid_q[fill_index][w]) begin
        f_inv  = 1'b1;
        f_iway = WAY_W'(w);
      end
    end
    rr_adv = !f_match && !f_inv;
    f_sel  = f_match ? f_mway : (f_inv ? f_iway : rr_q[fill_index]);
  end

  always_ff @(posedge clk) begin
    if (fill_acc) tag_mem[fill_index][f_sel] <= fill_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (state_q == FLUSH) begin
      valid_q[cnt_q] <= '0;
      rr_q[cnt_q]    <= '0;
    end else if (fill_acc) begin
      valid_q[fill_index][f_sel] <= 1'b1;
      if (rr_adv) rr_q[fill_index] <= rr_q[fill_index] + WAY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_way   <= '0;
      fill_done <= 1'b0;
      fill_way  <= '0;
    end else begin
      rsp_valid <= lk_acc;
      rsp_hit   <= lk_acc && lk_hit;
      rsp_way   <= (lk_acc && lk_hit) ? lk_way : '0;
      fill_done <= fill_acc;
      if (fill_acc) fill_way <= f_sel;
    end
  end

endmodule

// File: tb/tb_cache_tag_lookup.sv
// tb/tb_cache_tag_lookup.sv - scoreboard bench for cache_tag_lookup
module tb_cache_tag_lookup;
  localparam int TAG_W = 8;
  localparam int SETS  = 32;
  localparam int WAYS  = 4;
  localparam int IDX_W = 5;
  localparam int WAY_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             lk_valid = 1'b0;
  logic             lk_ready;
  logic [IDX_W-1:0] lk_index = '0;
  logic [TAG_W-1:0] lk_tag = '0;
  logic             rsp_valid, rsp_hit;
  logic [WAY_W-1:0] rsp_way;
  logic             fill_valid = 1'b0;
  logic             fill_ready;
  logic [IDX_W-1:0] fill_index = '0;
  logic [TAG_W-1:0] fill_tag = '0;
  logic [WAY_W-1:0] fill_way;
  logic             fill_done;
  logic             flush_req = 1'b0;
  logic             flush_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int rsp_q[$];
  int fill_q[$];

  cache_tag_lookup #(.TAG_W(TAG_W), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_index(lk_index), .lk_tag(lk_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_index(fill_index),
    .fill_tag(fill_tag), .fill_way(fill_way), .fill_done(fill_done),
    .flush_req(flush_req), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected responses encoded as {hit, way}.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rsp_q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        int e;
        e = rsp_q.pop_front();
        chk("rsp_hit", rsp_hit, e >> WAY_W);
        chk("rsp_way", rsp_way, e & (WAYS - 1));
      end
    end
    if (fill_done) begin
      if (fill_q.size() == 0) chk("unexpected_fill_done", 1, 0);
      else chk("fill_way", fill_way, fill_q.pop_front());
    end
  end

  task automatic lookup(input int idx, input int tag, input int hit, input int way);
    lk_index = IDX_W'(idx);
    lk_tag   = TAG_W'(tag);
    lk_valid = 1'b1;
    rsp_q.push_back((hit << WAY_W) | way);
    @(negedge clk);
    chk("lk_ready", lk_ready, 1);
    @(posedge clk);
    #1 lk_valid = 1'b0;
  endtask

  task automatic fill(input int idx, input int tag, input int way);
    fill_index = IDX_W'(idx);
    fill_tag   = TAG_W'(tag);
    fill_valid = 1'b1;
    fill_q.push_back(way);
    @(negedge clk);
    chk("fill_ready", fill_ready, 1);
    @(posedge clk);
    #1 fill_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt;
    int fill_seq [5] = '{0, 1, 2, 3, 0};

    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_way", rsp_way, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_fill_way", fill_way, 0);
    chk("rst_flush_busy", flush_busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(1);

    lookup(0, 'h01, 0, 0);
    idle(2);

    for (int i = 0; i < 4; i++) fill(3, 'h10 + i, i);
    lookup(3, 'h12, 1, 2);
    lookup(4, 'h12, 0, 0);
    fill(3, 'h11, 1);
    for (int i = 0; i < 5; i++) fill(3, 'h20 + i, fill_seq[i]);
    lookup(3, 'h10, 0, 0);
    lookup(3, 'h24, 1, 0);
    lookup(3, 'h21, 1, 1);
    // rr is now 1: rewriting a present tag must not move it.
    fill(3, 'h22, 2);
    fill(3, 'h25, 1);
    lookup(3, 'h25, 1, 1);

    fill_index = 5; fill_tag = 'h33; fill_valid = 1'b1;
    lk_index = 5;   lk_tag = 'h33;   lk_valid = 1'b1;
    fill_q.push_back(0);
    rsp_q.push_back(0);
    @(posedge clk); #1 fill_valid = 1'b0; lk_valid = 1'b0;
    lookup(5, 'h33, 1, 0);

    fill(0, 'h40, 0);
    fill(31, 'h41, 0);
    lookup(0, 'h40, 1, 0);
    idle(2);

    flush_req = 1'b1;
    lk_valid = 1'b1; lk_index = 0; lk_tag = 'h40;
    @(negedge clk);
    chk("ready_at_flush_req", lk_ready, 0);
    @(posedge clk); #1 flush_req = 1'b0; lk_valid = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (flush_busy) begin
        busy_cnt++;
        chk("flush_lk_ready", lk_ready, 0);
        chk("flush_fill_ready", fill_ready, 0);
      end
    end
    chk("flush_busy_cycles", busy_cnt, SETS);
    @(posedge clk); #1;

    lookup(0, 'h40, 0, 0);
    lookup(31, 'h41, 0, 0);
    lookup(3, 'h24, 0, 0);
    lookup(5, 'h33, 0, 0);
    fill(0, 'h50, 0);
    fill(31, 'h41, 0);
    idle(2);

    flush_req = 1'b1;
    @(posedge clk); #1 flush_req = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40 && busy_cnt < 10; c++) begin
      @(negedge clk);
      if (flush_busy) busy_cnt++;
    end
    chk("busy_before_reset", busy_cnt, 10);
    rst_n = 1'b0;
    #1;
    chk("abort_flush_busy", flush_busy, 0);
    chk("abort_lk_ready", lk_ready, 1);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    lookup(0, 'h50, 0, 0);
    lookup(31, 'h41, 0, 0);
    fill(0, 'h60, 0);

    for (int c = 0; c < 20 && (rsp_q.size() + fill_q.size()) != 0; c++) @(posedge clk);
    idle(2);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("fill_q_drained", fill_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_tag_lookup.md
Name: cache_tag_lookup

Overview:
- Parametrised set-associative cache tag array with valid bits and registered hit/miss lookup.
- Provides a fill port with per-set replacement (first invalid way, else round-robin) and a multi-cycle flush sequencer.
- Sits between the request front-end and the data array; rsp_way selects the data column on a hit.

Parameters:
- TAG_W, 8, tag width in bits.
- SETS, 32, number of sets (rows); must be a power of two, minimum 2.
- WAYS, 4, associativity (columns); must be a power of two, minimum 2.
- IDX_W, $clog2(SETS), derived set-index width; not to be overridden.
- WAY_W, $clog2(WAYS), derived way-number width; not to be overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lk_valid  in  1  lookup request valid.
- lk_ready  out  1  lookup accepted when lk_valid && lk_ready.
- lk_index  in  IDX_W  set to search.
- lk_tag  in  TAG_W  tag to compare.
- rsp_valid  out  1  one-cycle lookup result strobe.
- rsp_hit  out  1  1 = hit, 0 = miss.
- rsp_way  out  WAY_W  way that hit; 0 on miss.
- fill_valid  in  1  install tag request.
- fill_ready  out  1  fill accepted when fill_valid && fill_ready.
- fill_index  in  IDX_W  set to install into.
- fill_tag  in  TAG_W  tag to install.
- fill_way  out  WAY_W  way written by the accepted fill (valid the cycle after acceptance, with fill_done).
- fill_done  out  1  one-cycle strobe after a fill is written.
- flush_req  in  1  invalidate-all request (level, sampled in IDLE).
- flush_busy  out  1  high while flush is in progress.

Behaviour:
- Reset (async, rst_n=0):
  - All valid bits = 0; all round-robin pointers = 0; FSM = IDLE.
  - rsp_valid = 0, rsp_hit = 0, rsp_way = 0, fill_done = 0, fill_way = 0, flush_busy = 0.
  - Tag storage is not reset.
  - Reset mid-flush or mid-lookup aborts it: no rsp_valid or fill_done after release.
- FSM states: IDLE, FLUSH.
  - IDLE -> FLUSH when flush_req=1. The flush counter loads 0 and flush_busy rises next cycle.
  - FLUSH clears all valid bits and the rr pointer of set cnt each cycle, then cnt++.
  - FLUSH -> IDLE after clearing set SETS-1. Duration is exactly SETS cycles of flush_busy=1.
  - A flush_req held high on return to IDLE starts a new flush.
- Readiness:
  - lk_ready = fill_ready = (state==IDLE) && !flush_req.
  - A request presented in the cycle flush_req is first seen is not accepted.
- Lookup (latency 1):
  - Compares lk_tag against all WAYS entries of lk_index.
  - Hit = any way with valid=1 and equal tag.
  - Next cycle: rsp_valid=1, rsp_hit, rsp_way = lowest-numbered matching way; on miss rsp_hit=0, rsp_way=0.
  - rsp_valid is 1 for exactly one cycle per accepted lookup; back-to-back lookups give back-to-back responses.
  - Invalid ways never hit, even when the stale tag matches.
- Fill (write at acceptance edge; fill_done/fill_way next cycle). Way selection order:
  1. If fill_tag is already valid in the set, rewrite that way (no duplicates); rr pointer unchanged.
  2. Else the lowest-numbered invalid way; rr pointer unchanged.
  3. Else the way at rr[fill_index]; rr[fill_index] = rr+1 mod WAYS (wraps WAYS-1 -> 0).
- Simultaneous lookup and fill in the same cycle:
  - Both are accepted.
  - The lookup sees pre-fill contents, even for the same set and tag.
  - A lookup issued the following cycle sees the fill.
- Asserting flush_req while idle takes precedence over lk_valid and fill_valid in that cycle.

Test Plan:
- Reset, then lookup index 0 tag 0x01 -> rsp_valid=1, rsp_hit=0, rsp_way=0 one cycle after acceptance; no other rsp_valid pulses.
- Fill set 3 with tags 0x10, 0x11, 0x12, 0x13 (WAYS=4) -> fill_way 0,1,2,3. Lookup set 3 tag 0x12 -> hit, way 2. Lookup set 4 tag 0x12 -> miss.
- Set 3 full; fill 0x20, 0x21, 0x22, 0x23, 0x24 -> fill_way 0,1,2,3,0 (rr wrap). Lookup 0x10 -> miss; 0x24 -> hit way 0.
- Fill 0x11 again into set 3 after it is present in way 1 -> fill_way=1, rr unchanged (next new tag still goes to the expected rr way).
- Same cycle: lookup set 5 tag 0x33 plus fill set 5 tag 0x33 -> response is miss. Repeat the lookup next cycle -> hit way 0.
- Populate sets 0 and 31, pulse flush_req:
  - flush_busy high exactly 32 cycles; lk_ready=0 and fill_ready=0 throughout.
  - Afterwards all lookups miss; the next fill to set 0 gets way 0.
  - A second run asserts rst_n=0 at flush cycle 10 -> flush_busy=0 immediately; all lookups miss after release.
